// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller. Decides each cycle whether PC, IF/ID and the
// downstream pipeline registers advance, hold or flush. It also tracks data-memory
// wait states and keeps saturating performance counters.
module hazard_stall_ctrl #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             dmem_ack,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_freeze,
   output logic             state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic             timeout_err
);

   typedef enum logic {
      StRun  = 1'b0,
      StWait = 1'b1
   } state_e;

   localparam logic [15:0] MaxWait = 16'(MAX_WAIT);

   state_e           state_q, state_d;
   logic [15:0]      wait_ctr_q, wait_ctr_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;

   logic freeze;
   logic loaduse;
   logic branch_applied;
   logic loaduse_applied;

   // Hazard detection; a load to r0 never creates a dependency.
   always_comb begin
      freeze  = mem_req & ~dmem_ack;
      loaduse = ex_memread & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
   end

   // Mealy control outputs in strict priority: reset, freeze, branch, load-use.
   always_comb begin
      pc_write        = 1'b1;
      ifid_write      = 1'b1;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      pipe_freeze     = 1'b0;
      branch_applied  = 1'b0;
      loaduse_applied = 1'b0;
      if (!rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (freeze) begin
         // EX is held, so a pending branch or load-use re-presents afterwards.
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         pipe_freeze = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush     = 1'b1;
         idex_flush     = 1'b1;
         branch_applied = 1'b1;
      end else if (loaduse) begin
         pc_write        = 1'b0;
         ifid_write      = 1'b0;
         idex_flush      = 1'b1;
         loaduse_applied = 1'b1;
      end
   end

   // Next-state for the wait FSM, wait counter, sticky timeout and counters.
   always_comb begin
      state_d       = state_q;
      wait_ctr_d    = wait_ctr_q;
      timeout_d     = timeout_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      loaduse_cnt_d = loaduse_cnt_q;

      unique case (state_q)
         StRun: begin
            if (freeze) begin
               state_d    = StWait;
               wait_ctr_d = '0;
            end
         end
         StWait: begin
            if (!freeze) state_d = StRun;
            if (wait_ctr_q != 16'hFFFF) wait_ctr_d = wait_ctr_q + 16'd1;
            if (freeze && (wait_ctr_q == MaxWait)) timeout_d = 1'b1;
         end
         default: state_d = StRun;
      endcase

      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (branch_applied && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (loaduse_applied && (loaduse_cnt_q != '1)) begin
         loaduse_cnt_d = loaduse_cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StRun;
         wait_ctr_q    <= '0;
         timeout_q     <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         loaduse_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_ctr_q    <= wait_ctr_d;
         timeout_q     <= timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         loaduse_cnt_q <= loaduse_cnt_d;
      end
   end

   assign state       = state_q;
   assign timeout_err = timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign loaduse_cnt = loaduse_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model built from the hazard and counting rules.
module tb_hazard_stall_ctrl;

   localparam int unsigned CW   = 4;
   localparam int unsigned MW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs, id_rt, ex_rt;
   logic          id_uses_rt, ex_memread, ex_branch_taken, mem_req, dmem_ack;
   logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, state;
   logic [CW-1:0] stall_cnt, flush_cnt, loaduse_cnt;
   logic          timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counts and the length of the current freeze run.
   int m_stall, m_flush, m_lu, m_run;
   bit m_to;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rt     (id_uses_rt),
      .ex_memread     (ex_memread),
      .ex_rt          (ex_rt),
      .ex_branch_taken(ex_branch_taken),
      .mem_req        (mem_req),
      .dmem_ack       (dmem_ack),
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .pipe_freeze    (pipe_freeze),
      .state          (state),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt),
      .loaduse_cnt    (loaduse_cnt),
      .timeout_err    (timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}.
   function automatic logic [4:0] exp_ctrl();
      logic fr, lu;
      fr = mem_req & ~dmem_ack;
      lu = ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (!rst) return 5'b00110;
      if (fr) return 5'b00001;
      if (ex_branch_taken) return 5'b11110;
      if (lu) return 5'b00010;
      return 5'b11000;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   function automatic void model_clear();
      m_stall = 0;
      m_flush = 0;
      m_lu    = 0;
      m_run   = 0;
      m_to    = 1'b0;
   endfunction

   // One cycle: check everything mid-cycle, then advance the model at the edge.
   task automatic step();
      logic [4:0] e;
      logic       fr;
      int         k;
      @(negedge clk);
      e  = exp_ctrl();
      fr = mem_req & ~dmem_ack;
      check_eq("pc_write", pc_write, e[4]);
      check_eq("ifid_write", ifid_write, e[3]);
      check_eq("ifid_flush", ifid_flush, e[2]);
      check_eq("idex_flush", idex_flush, e[1]);
      check_eq("pipe_freeze", pipe_freeze, e[0]);
      check_eq("state", state, m_run > 0);
      check_eq("stall_cnt", stall_cnt, m_stall);
      check_eq("flush_cnt", flush_cnt, m_flush);
      check_eq("loaduse_cnt", loaduse_cnt, m_lu);
      check_eq("timeout_err", timeout_err, m_to);
      @(posedge clk);
      if (!rst) begin
         model_clear();
      end else begin
         k = m_run;  // freeze cycles immediately preceding this one
         if (!e[4]) m_stall = sat_inc(m_stall);
         if (e == 5'b11110) m_flush = sat_inc(m_flush);
         if (e == 5'b00010) m_lu = sat_inc(m_lu);
         // k-th freeze cycle of a run sees a wait count of k-1.
         if (fr && (k >= int'(MW) + 1)) m_to = 1'b1;
         m_run = fr ? k + 1 : 0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_uses_rt      = 1'b0;
      ex_memread      = 1'b0;
      ex_rt           = 5'd0;
      ex_branch_taken = 1'b0;
      mem_req         = 1'b0;
      dmem_ack        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_clear();
      step();  // reset-state values with rst held low
      rst = 1'b1;

      // Load-use on rs: one bubble.
      ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      step();
      ex_memread = 1'b0;
      step();
      check_eq("lu_loaduse_cnt", loaduse_cnt, 1);
      check_eq("lu_stall_cnt", stall_cnt, 1);

      // Load-use through rt only counts when rt is a source.
      do_reset();
      ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b0;
      step();
      id_uses_rt = 1'b1;
      step();
      check_eq("rt_loaduse_cnt", loaduse_cnt, 1);

      // Load to r0 never stalls.
      do_reset();
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      step();
      check_eq("r0_stall_cnt", stall_cnt, 0);

      // Branch overrides load-use.
      do_reset();
      ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
      step();
      idle_inputs();
      step();
      check_eq("br_flush_cnt", flush_cnt, 1);
      check_eq("br_loaduse_cnt", loaduse_cnt, 0);

      // Memory wait of three cycles, then ack; ack with req gives no freeze.
      do_reset();
      mem_req = 1'b1;
      repeat (3) step();
      check_eq("mw_state_wait", state, 1);
      dmem_ack = 1'b1;
      step();
      check_eq("mw_state_run", state, 0);
      check_eq("mw_stall_cnt", stall_cnt, 3);
      step();
      idle_inputs();
      step();

      // Branch held through a two-cycle freeze is applied once per free cycle.
      do_reset();
      ex_branch_taken = 1'b1; mem_req = 1'b1;
      repeat (2) step();
      mem_req = 1'b0;
      repeat (2) step();
      idle_inputs();
      step();
      check_eq("fb_flush_cnt", flush_cnt, 2);

      // Timeout after a long wait, sticky through ack, cleared by reset.
      do_reset();
      mem_req = 1'b1;
      repeat (5) step();
      check_eq("to_not_yet", timeout_err, 0);
      step();
      check_eq("to_set", timeout_err, 1);
      dmem_ack = 1'b1;
      step();
      check_eq("to_sticky", timeout_err, 1);
      idle_inputs();
      rst = 1'b0; mem_req = 1'b1;  // reset mid-request
      step();
      rst = 1'b1; mem_req = 1'b0;
      check_eq("to_cleared", timeout_err, 0);
      check_eq("to_state", state, 0);
      check_eq("to_stall_cnt", stall_cnt, 0);

      // Counter saturation.
      do_reset();
      ex_memread = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
      repeat (CMAX + 4) step();
      check_eq("sat_loaduse_cnt", loaduse_cnt, CMAX);
      idle_inputs();

      // Random traffic in phases with different ack rates.
      for (int ph = 0; ph < 30; ph++) begin
         int ack_pct;
         ack_pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 30 : 70);
         for (int c = 0; c < 100; c++) begin
            rst             = ($urandom_range(63) != 0);
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            id_uses_rt      = 1'($urandom_range(1));
            ex_memread      = 1'($urandom_range(1));
            ex_rt           = 5'($urandom_range(3));
            ex_branch_taken = ($urandom_range(99) < 20);
            mem_req         = ($urandom_range(99) < 60);
            dmem_ack        = ($urandom_range(99) < ack_pct);
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
